// File: rtl/aes_host_ctrl.sv
// Host-side command controller for the AES128 core: accepts blocks, issues start
// pulses with chaining, watches for the core result and buffers one response.
module aes_host_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         aes_clk,
  input  logic         aes_rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [127:0] req_data,
  input  logic         req_decrypt,
  input  logic         req_last,
  input  logic [127:0] cfg_key,
  input  logic [3:0]   cfg_mode,
  input  logic [127:0] cfg_iv,
  input  logic [3:0]   cfg_segment_len,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_last,
  output logic         rsp_timeout,
  output logic         aes_cipher_en,
  output logic         aes_decipher_en,
  output logic         aes_chain_en,
  output logic [127:0] aes_data_in,
  output logic [127:0] aes_key,
  output logic [127:0] aes_init_vector,
  output logic [3:0]   aes_mode,
  output logic [3:0]   aes_segment_len,
  input  logic [127:0] aes_data_out,
  input  logic         aes_ready
);

  localparam int unsigned DATA_W = 128;
  localparam int unsigned CFG_W  = 4;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic                in_msg_q, in_msg_d;
  logic                dec_q, dec_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                req_ready_d, rsp_valid_d, rsp_last_d, rsp_timeout_d;
  logic                cipher_d, decipher_d, chain_d;
  logic [DATA_W-1:0]   rsp_data_d, data_in_d, key_d, iv_d;
  logic [CFG_W-1:0]    mode_d, seg_d;

  // State and all output registers
  always_ff @(posedge aes_clk or posedge aes_rst) begin
    if (aes_rst) begin
      state_q         <= IDLE;
      in_msg_q        <= 1'b0;
      dec_q           <= 1'b0;
      last_q          <= 1'b0;
      cnt_q           <= '0;
      req_ready       <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_data        <= '0;
      rsp_last        <= 1'b0;
      rsp_timeout     <= 1'b0;
      aes_cipher_en   <= 1'b0;
      aes_decipher_en <= 1'b0;
      aes_chain_en    <= 1'b0;
      aes_data_in     <= '0;
      aes_key         <= '0;
      aes_init_vector <= '0;
      aes_mode        <= '0;
      aes_segment_len <= '0;
    end else begin
      state_q         <= state_d;
      in_msg_q        <= in_msg_d;
      dec_q           <= dec_d;
      last_q          <= last_d;
      cnt_q           <= cnt_d;
      req_ready       <= req_ready_d;
      rsp_valid       <= rsp_valid_d;
      rsp_data        <= rsp_data_d;
      rsp_last        <= rsp_last_d;
      rsp_timeout     <= rsp_timeout_d;
      aes_cipher_en   <= cipher_d;
      aes_decipher_en <= decipher_d;
      aes_chain_en    <= chain_d;
      aes_data_in     <= data_in_d;
      aes_key         <= key_d;
      aes_init_vector <= iv_d;
      aes_mode        <= mode_d;
      aes_segment_len <= seg_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    in_msg_d      = in_msg_q;
    dec_d         = dec_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    req_ready_d   = req_ready;
    rsp_valid_d   = rsp_valid;
    rsp_data_d    = rsp_data;
    rsp_last_d    = rsp_last;
    rsp_timeout_d = rsp_timeout;
    cipher_d      = aes_cipher_en;
    decipher_d    = aes_decipher_en;
    chain_d       = aes_chain_en;
    data_in_d     = aes_data_in;
    key_d         = aes_key;
    iv_d          = aes_init_vector;
    mode_d        = aes_mode;
    seg_d         = aes_segment_len;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready) begin
          data_in_d   = req_data;
          last_d      = req_last;
          req_ready_d = 1'b0;
          state_d     = ISSUE;
          // First block of a message snapshots direction and configuration
          if (!in_msg_q) begin
            dec_d      = req_decrypt;
            key_d      = cfg_key;
            mode_d     = cfg_mode;
            iv_d       = cfg_iv;
            seg_d      = cfg_segment_len;
            chain_d    = 1'b0;
            cipher_d   = ~req_decrypt;
            decipher_d = req_decrypt;
          end else begin
            chain_d    = 1'b1;
            cipher_d   = ~dec_q;
            decipher_d = dec_q;
          end
        end
      end
      ISSUE: begin
        cipher_d   = 1'b0;
        decipher_d = 1'b0;
        cnt_d      = '0;
        in_msg_d   = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        // A ready pulse on the watchdog edge still yields a normal result
        if (aes_ready) begin
          rsp_data_d    = aes_data_out;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_last_d    = last_q;
          state_d       = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          rsp_last_d    = last_q;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_timeout_d = 1'b0;
          req_ready_d   = 1'b1;
          state_d       = IDLE;
          if (rsp_last || rsp_timeout) in_msg_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_host_ctrl.sv
// Directed bench for aes_host_ctrl: instance 0 uses the default watchdog,
// instance 1 a short watchdog of 8 cycles; dsel routes stimulus to one of them.
module tb_aes_host_ctrl;

  logic         aes_clk = 1'b0;
  logic         aes_rst = 1'b1;
  logic         req_valid = 1'b0;
  logic [127:0] req_data = '0;
  logic         req_decrypt = 1'b0;
  logic         req_last = 1'b0;
  logic [127:0] cfg_key = '0;
  logic [3:0]   cfg_mode = '0;
  logic [127:0] cfg_iv = '0;
  logic [3:0]   cfg_segment_len = 4'h8;
  logic         rsp_ready = 1'b0;
  logic [127:0] aes_data_out = '0;
  logic         aes_ready = 1'b0;
  int           dsel = 0;

  logic         req_ready_o [2];
  logic         rsp_valid_o [2];
  logic [127:0] rsp_data_o [2];
  logic         rsp_last_o [2];
  logic         rsp_timeout_o [2];
  logic         aes_cipher_en_o [2];
  logic         aes_decipher_en_o [2];
  logic         aes_chain_en_o [2];
  logic [127:0] aes_data_in_o [2];
  logic [127:0] aes_key_o [2];
  logic [127:0] aes_init_vector_o [2];
  logic [3:0]   aes_mode_o [2];
  logic [3:0]   aes_segment_len_o [2];

  always #5 aes_clk = ~aes_clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    aes_host_ctrl #(.TIMEOUT_CYCLES(g == 0 ? 64 : 8)) u_dut (
      .aes_clk         (aes_clk),
      .aes_rst         (aes_rst),
      .req_valid       (req_valid & (dsel == g)),
      .req_ready       (req_ready_o[g]),
      .req_data        (req_data),
      .req_decrypt     (req_decrypt),
      .req_last        (req_last),
      .cfg_key         (cfg_key),
      .cfg_mode        (cfg_mode),
      .cfg_iv          (cfg_iv),
      .cfg_segment_len (cfg_segment_len),
      .rsp_valid       (rsp_valid_o[g]),
      .rsp_ready       (rsp_ready & (dsel == g)),
      .rsp_data        (rsp_data_o[g]),
      .rsp_last        (rsp_last_o[g]),
      .rsp_timeout     (rsp_timeout_o[g]),
      .aes_cipher_en   (aes_cipher_en_o[g]),
      .aes_decipher_en (aes_decipher_en_o[g]),
      .aes_chain_en    (aes_chain_en_o[g]),
      .aes_data_in     (aes_data_in_o[g]),
      .aes_key         (aes_key_o[g]),
      .aes_init_vector (aes_init_vector_o[g]),
      .aes_mode        (aes_mode_o[g]),
      .aes_segment_len (aes_segment_len_o[g]),
      .aes_data_out    (aes_data_out),
      .aes_ready       (aes_ready & (dsel == g))
    );
  end

  int checks = 0;
  int errors = 0;
  int cip_cnt = 0;
  int dec_cnt = 0;
  logic         obs_cip, obs_dec, obs_chain;
  logic [127:0] obs_din;

  // Count cycles each start enable is high on the selected instance
  always @(posedge aes_clk) begin
    if (aes_cipher_en_o[dsel])   cip_cnt <= cip_cnt + 1;
    if (aes_decipher_en_o[dsel]) dec_cnt <= dec_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] outs(input int i);
    return 128'({|rsp_data_o[i], |aes_data_in_o[i], |aes_key_o[i], |aes_init_vector_o[i],
                 aes_mode_o[i], aes_segment_len_o[i], req_ready_o[i], rsp_valid_o[i],
                 rsp_last_o[i], rsp_timeout_o[i], aes_cipher_en_o[i], aes_decipher_en_o[i],
                 aes_chain_en_o[i]});
  endfunction

  task automatic tick();
    @(posedge aes_clk);
    #1;
  endtask

  task automatic send(input logic [127:0] data, input logic dec, input logic last,
                      input logic [127:0] key, input logic [127:0] iv, input logic [3:0] mode);
    int n = 0;
    while (!req_ready_o[dsel] && n < 20) begin
      tick();
      n++;
    end
    check("req_ready_wait", 128'(req_ready_o[dsel]), 128'(1));
    req_data = data; req_decrypt = dec; req_last = last;
    cfg_key = key; cfg_iv = iv; cfg_mode = mode;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    obs_cip   = aes_cipher_en_o[dsel];
    obs_dec   = aes_decipher_en_o[dsel];
    obs_chain = aes_chain_en_o[dsel];
    obs_din   = aes_data_in_o[dsel];
  endtask

  // Pulse aes_ready on the edge 'delay' edges after the accept edge
  task automatic core_reply(input int delay, input logic [127:0] data);
    repeat (delay - 1) tick();
    aes_ready = 1'b1;
    aes_data_out = data;
    tick();
    aes_ready = 1'b0;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] IV1 = 128'h0f0e0d0c0b0a09080706050403020100;

  initial begin
    int c0, d0;
    // Reset
    tick(); tick();
    check("rst_outs0", outs(0), '0);
    check("rst_outs1", outs(1), '0);
    aes_rst = 1'b0;
    tick();
    check("idle_req_ready", 128'(req_ready_o[0]), 128'(1));

    // Single ECB block, 10-cycle core
    c0 = cip_cnt;
    send(PT, 1'b0, 1'b1, K1, IV1, 4'h1);
    check("t1_cipher_en", 128'(obs_cip), 128'(1));
    check("t1_decipher_en", 128'(obs_dec), 128'(0));
    check("t1_chain", 128'(obs_chain), 128'(0));
    check("t1_data_in", obs_din, PT);
    check("t1_req_ready_busy", 128'(req_ready_o[0]), 128'(0));
    core_reply(10, CT);
    check("t1_rsp_valid", 128'(rsp_valid_o[0]), 128'(1));
    check("t1_rsp_data", rsp_data_o[0], CT);
    check("t1_rsp_last", 128'(rsp_last_o[0]), 128'(1));
    check("t1_rsp_timeout", 128'(rsp_timeout_o[0]), 128'(0));
    check("t1_seg_len", 128'(aes_segment_len_o[0]), 128'(8));
    take_rsp();
    check("t1_rsp_done", 128'(rsp_valid_o[0]), 128'(0));
    check("t1_req_ready_back", 128'(req_ready_o[0]), 128'(1));
    check("t1_pulses", 128'(cip_cnt - c0), 128'(1));

    // Three-block CBC message, key changes mid-message
    send(128'h1, 1'b0, 1'b0, K1, IV1, 4'h2);
    check("cbc1_chain", 128'(obs_chain), 128'(0));
    core_reply(3, 128'hA1);
    take_rsp();
    send(128'h2, 1'b0, 1'b0, K2, 128'h5, 4'h3);
    check("cbc2_chain", 128'(obs_chain), 128'(1));
    check("cbc2_key", aes_key_o[0], K1);
    check("cbc2_iv", aes_init_vector_o[0], IV1);
    check("cbc2_mode", 128'(aes_mode_o[0]), 128'(2));
    core_reply(3, 128'hA2);
    check("cbc2_rsp_data", rsp_data_o[0], 128'hA2);
    check("cbc2_rsp_last", 128'(rsp_last_o[0]), 128'(0));
    take_rsp();
    send(128'h3, 1'b0, 1'b1, K2, 128'h5, 4'h3);
    check("cbc3_chain", 128'(obs_chain), 128'(1));
    core_reply(3, 128'hA3);
    check("cbc3_rsp_last", 128'(rsp_last_o[0]), 128'(1));
    take_rsp();
    send(128'h4, 1'b0, 1'b1, K2, 128'h5, 4'h3);
    check("cbc_new_chain", 128'(obs_chain), 128'(0));
    check("cbc_new_key", aes_key_o[0], K2);
    core_reply(2, 128'hA4);
    take_rsp();

    // Decipher direction
    c0 = cip_cnt; d0 = dec_cnt;
    send(CT, 1'b1, 1'b1, K1, IV1, 4'h1);
    check("dec_decipher_en", 128'(obs_dec), 128'(1));
    check("dec_cipher_en", 128'(obs_cip), 128'(0));
    core_reply(4, PT);
    take_rsp();
    check("dec_cip_pulses", 128'(cip_cnt - c0), 128'(0));
    check("dec_dec_pulses", 128'(dec_cnt - d0), 128'(1));

    // Back-pressure with spurious aes_ready during RESP
    send(128'hB0, 1'b0, 1'b1, K1, IV1, 4'h1);
    core_reply(2, 128'hBEEF);
    for (int i = 0; i < 20; i++) begin
      aes_ready = i[0];
      aes_data_out = ~128'hBEEF;
      tick();
    end
    aes_ready = 1'b0;
    check("bp_rsp_data", rsp_data_o[0], 128'hBEEF);
    check("bp_rsp_valid", 128'(rsp_valid_o[0]), 128'(1));
    check("bp_req_ready", 128'(req_ready_o[0]), 128'(0));
    take_rsp();

    // Reset during WAIT of a mid-message block
    send(128'hC0, 1'b0, 1'b0, K1, IV1, 4'h1);
    tick(); tick();
    aes_rst = 1'b1;
    #1;
    check("rst_wait_outs", outs(0), '0);
    #1;
    aes_rst = 1'b0;
    send(128'hC1, 1'b0, 1'b1, K2, IV1, 4'h1);
    check("rst_post_chain", 128'(obs_chain), 128'(0));
    core_reply(2, 128'hC2);
    take_rsp();

    // Watchdog on the 8-cycle instance
    dsel = 1;
    send(128'hD0, 1'b0, 1'b0, K1, IV1, 4'h1);
    tick();
    repeat (7) tick();
    check("to_not_yet", 128'(rsp_valid_o[1]), 128'(0));
    tick();
    check("to_rsp_valid", 128'(rsp_valid_o[1]), 128'(1));
    check("to_rsp_timeout", 128'(rsp_timeout_o[1]), 128'(1));
    check("to_rsp_data", rsp_data_o[1], '0);
    take_rsp();
    check("to_timeout_clr", 128'(rsp_timeout_o[1]), 128'(0));
    send(128'hD1, 1'b0, 1'b0, K1, IV1, 4'h1);
    check("to_next_chain", 128'(obs_chain), 128'(0));
    core_reply(9, 128'hD2);
    check("edge_rsp_valid", 128'(rsp_valid_o[1]), 128'(1));
    check("edge_rsp_timeout", 128'(rsp_timeout_o[1]), 128'(0));
    check("edge_rsp_data", rsp_data_o[1], 128'hD2);
    take_rsp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule

// File: doc/aes_host_ctrl.md
# aes_host_ctrl

Host-side command controller that drives the AES128 core's input bus and consumes its `aes_data_out`/`aes_ready` result port. It accepts 128-bit blocks from an upstream valid/ready stream, issues single-cycle cipher/decipher start pulses with correct chaining, waits for the core's ready pulse (with a watchdog), and returns each result through a one-entry valid/ready response buffer. It sits between the system-side data mover and the AES core.

## Interface
- TIMEOUT_CYCLES, 64, WAIT cycles without `aes_ready` before the block is aborted; legal range 2..65535.

- aes_clk  in  1  clock; all flops rising-edge.
- aes_rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  upstream block valid.
- req_ready  out  1  block accepted on edge with req_valid&req_ready.
- req_data  in  128  plaintext/ciphertext block.
- req_decrypt  in  1  1 = decipher; sampled on first block of a message only.
- req_last  in  1  marks final block of a message.
- cfg_key  in  128  key; sampled on first block of a message.
- cfg_mode  in  4  AES mode code; sampled on first block.
- cfg_iv  in  128  initial vector; sampled on first block.
- cfg_segment_len  in  4  CFB segment length; sampled on first block.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accepts result.
- rsp_data  out  128  result block (0 on timeout).
- rsp_last  out  1  copy of req_last of the block.
- rsp_timeout  out  1  block aborted by watchdog.
- aes_cipher_en  out  1  one-cycle cipher start pulse.
- aes_decipher_en  out  1  one-cycle decipher start pulse.
- aes_chain_en  out  1  0 = first block (core loads IV), 1 = chained block.
- aes_data_in  out  128  block to core.
- aes_key, aes_init_vector  out  128 each  latched key / IV.
- aes_mode, aes_segment_len  out  4 each  latched mode / segment length.
- aes_data_out  in  128  core result.
- aes_ready  in  1  one-cycle pulse: aes_data_out valid.

## Operation
- All outputs registered. Reset values: every output 0, including req_ready; internal state IDLE, in_msg=0, counter=0.
- FSM states IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On accept edge: latch req_data, req_last; if in_msg=0 also latch req_decrypt and all cfg_* into aes_key/aes_mode/aes_init_vector/aes_segment_len, set aes_chain_en=0; else aes_chain_en=1, cfg_* ignored. Assert aes_cipher_en (or aes_decipher_en per latched direction); req_ready→0; go ISSUE.
- ISSUE: held exactly one cycle; next edge drops both enables, clears counter, go WAIT. in_msg←1.
- WAIT: edge with aes_ready=1 captures aes_data_out into rsp_data, rsp_timeout=0, rsp_valid=1, go RESP. Edge with aes_ready=0 and counter==TIMEOUT_CYCLES-1: rsp_data=0, rsp_timeout=1, rsp_valid=1, go RESP. Otherwise counter+1 (16-bit, never wraps because bounded).
- aes_ready coincident with the timeout edge: ready wins, normal result.
- RESP: rsp_* held stable while rsp_valid&~rsp_ready. Edge with rsp_ready: rsp_valid→0, rsp_timeout→0, req_ready→1, go IDLE; if rsp_last or rsp_timeout then in_msg→0 (next block starts new message with aes_chain_en=0).
- aes_ready in IDLE/ISSUE/RESP ignored, no state change.
- aes_data_in, aes_key, aes_mode, aes_init_vector, aes_segment_len, aes_chain_en stable from ISSUE through WAIT.
- Reset asserted mid-block: immediate return to reset values; pending block and response discarded.

## Timing
- Accept at edge E0 → enable high cycle E0..E1 → WAIT from E1.
- aes_ready sampled high at edge Ek → rsp_valid high from Ek.
- rsp_ready at edge Er → req_ready high from Er; next accept earliest Er+1.
- Min turnaround with 1-cycle core: 4 edges per block.
- Timeout: rsp_valid rises at edge E1+TIMEOUT_CYCLES when no aes_ready.

## Test plan
- Reset then single block, req_data=0x00112233445566778899aabbccddeeff, req_last=1, mode ECB, core model returns 0x69c4e0d86a7b0430d8cdb78070b4c55a 10 cycles after start → exactly one aes_cipher_en pulse, aes_chain_en=0, rsp_data matches, rsp_last=1, rsp_timeout=0.
- Three-block CBC message (last on 3rd), cfg_key changed between blocks → aes_chain_en 0,1,1; aes_key unchanged from block 1; following message shows aes_chain_en=0.
- req_decrypt=1 → only aes_decipher_en pulses; aes_cipher_en stays 0.
- Core never responds, TIMEOUT_CYCLES=8 → rsp_valid at 8th WAIT edge, rsp_data=0, rsp_timeout=1; next block uses aes_chain_en=0. aes_ready on exactly the 8th edge → normal result.
- rsp_ready held low 20 cycles, spurious aes_ready pulses during RESP → rsp_data unchanged, req_ready stays 0.
- Reset asserted during WAIT → all outputs 0 asynchronously; post-release block starts with aes_chain_en=0.
